// File: rtl/lsu_byte_sequencer_if.sv
// Request/response handshake and byte-wide memory port of the load/store sequencer.
interface lsu_byte_sequencer_if #(parameter int ADDR_W = 9);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic              mem_enable;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_sign, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_enable, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_sign, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_enable, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer: alignment check, big-endian byte transfers,
// load assembly with sign/zero extension and a one-cycle completion pulse.
module lsu_byte_sequencer #(
  parameter int ADDR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  lsu_byte_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              wr_q, sign_q, fault_q;
  logic [1:0]        size_q, cnt_q, last_idx, sel;
  logic [ADDR_W-1:0] base_q, last_addr_q, cur_addr;
  logic [31:0]       wdata_q, acc_q;
  logic [7:0]        store_byte;
  logic              req_fault, in_access, in_resp;

  function automatic logic [31:0] extend_load(input logic [31:0] acc,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic signed [31:0] ext;
    case (size)
      2'b00:   ext = {{24{sgn & acc[7]}}, acc[7:0]};
      2'b01:   ext = {{16{sgn & acc[15]}}, acc[15:0]};
      default: ext = acc;
    endcase
    return ext;
  endfunction

  always_comb begin
    req_fault = (bus.req_size == 2'b11) ||
                (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    case (size_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
    cur_addr = base_q + ADDR_W'(cnt_q);
    // Store bytes leave most-significant first, so index down from the top.
    sel        = last_idx - cnt_q;
    store_byte = wdata_q[{sel, 3'b000} +: 8];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = req_fault ? RESP : ACCESS;
      ACCESS:  if (cnt_q == last_idx) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      sign_q      <= 1'b0;
      fault_q     <= 1'b0;
      size_q      <= 2'b00;
      cnt_q       <= 2'd0;
      base_q      <= '0;
      last_addr_q <= '0;
      wdata_q     <= 32'd0;
      acc_q       <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.req_valid) begin
          wr_q    <= bus.req_write;
          size_q  <= bus.req_size;
          sign_q  <= bus.req_sign;
          base_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          fault_q <= req_fault;
          cnt_q   <= 2'd0;
          acc_q   <= 32'd0;
        end
        ACCESS: begin
          acc_q       <= {acc_q[23:0], bus.mem_rdata};
          last_addr_q <= cur_addr;
          if (cnt_q != last_idx) cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Reset masks the port immediately so an aborted store issues no further byte.
  assign in_access      = (state == ACCESS) && !reset;
  assign in_resp        = (state == RESP) && !reset;
  assign bus.req_ready  = (state == IDLE) && !reset;
  assign bus.mem_enable = in_access;
  assign bus.mem_write  = in_access && wr_q;
  assign bus.mem_wdata  = (in_access && wr_q) ? store_byte : 8'd0;
  assign bus.mem_addr   = reset ? '0 : ((state == ACCESS) ? cur_addr : last_addr_q);
  assign bus.resp_valid = in_resp;
  assign bus.resp_fault = in_resp && fault_q;
  assign bus.resp_rdata = (in_resp && !wr_q && !fault_q) ? extend_load(acc_q, size_q, sign_q) : 32'd0;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed bench for lsu_byte_sequencer with a byte memory model and scoreboard queues.
module tb_lsu_byte_sequencer;
  localparam int ADDR_W = 9;

  typedef struct packed {
    logic [8:0] addr;
    logic       wr;
    logic [7:0] wdata;
  } op_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } resp_t;

  logic clk = 1'b0;
  logic reset;
  logic mem_ready = 1'b0;
  logic [7:0] mem [512];
  logic [7:0] ref_mem [512];
  op_t   exp_ops [$];
  resp_t exp_resp [$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_resp_cyc = -10;

  always #5 clk = ~clk;

  lsu_byte_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
  lsu_byte_sequencer #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (bus.mem_enable && bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Monitor: memory port and responses checked against the scoreboard queues.
  always @(negedge clk) begin
    op_t   op;
    resp_t r;
    if (!reset && mem_ready) begin
      if (bus.mem_enable) begin
        if (exp_ops.size() == 0) chk("unexpected_mem_enable", 32'(bus.mem_enable), 32'd0);
        else begin
          op = exp_ops.pop_front();
          chk("mem_addr", 32'(bus.mem_addr), 32'(op.addr));
          chk("mem_write", 32'(bus.mem_write), 32'(op.wr));
          chk("mem_wdata", 32'(bus.mem_wdata), 32'(op.wdata));
        end
      end else begin
        chk("idle_mem_zero", 32'({bus.mem_write, bus.mem_wdata}), 32'd0);
      end
      if (bus.resp_valid) begin
        if (exp_resp.size() == 0) chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
        else begin
          r = exp_resp.pop_front();
          chk("resp_rdata", bus.resp_rdata, r.rdata);
          chk("resp_fault", 32'(bus.resp_fault), 32'(r.fault));
          chk("resp_cycle", 32'(cyc), 32'(r.due));
          chk("ready_low_in_resp", 32'(bus.req_ready), 32'd0);
        end
        last_resp_cyc = cyc;
      end else if (cyc == last_resp_cyc + 1) begin
        chk("ready_after_resp", 32'(bus.req_ready), 32'd1);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [8:0] addr, input logic [31:0] wd,
                        input logic hold, output int t_hs);
    logic        fault;
    int          n, k;
    logic [8:0]  a;
    logic [31:0] acc, b, rd;
    resp_t       r;
    fault = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    acc = 32'd0;
    if (!fault) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 9'(i);
        if (wr) begin
          b = wd >> (8 * (n - 1 - i));
          exp_ops.push_back('{addr: a, wr: 1'b1, wdata: b[7:0]});
          ref_mem[a] = b[7:0];
        end else begin
          exp_ops.push_back('{addr: a, wr: 1'b0, wdata: 8'd0});
          acc = {acc[23:0], ref_mem[a]};
        end
      end
    end
    if (wr || fault)     rd = 32'd0;
    else if (sz == 2'b00) rd = {{24{sg & acc[7]}}, acc[7:0]};
    else if (sz == 2'b01) rd = {{16{sg & acc[15]}}, acc[15:0]};
    else                  rd = acc;

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size  = sz;
    bus.req_sign  = sg;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) chk("ready_timeout", 32'(bus.req_ready), 32'd1);
    t_hs = cyc;
    r.rdata = rd;
    r.fault = fault;
    r.due   = fault ? t_hs + 1 : t_hs + n + 1;
    exp_resp.push_back(r);
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_resp.size() != 0 || exp_ops.size() != 0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", 32'(exp_resp.size() + exp_ops.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    logic [7:0] pre42, pre43;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_sign  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = 32'd0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'(i) ^ 8'hA5;

    repeat (2) @(posedge clk);
    #1 mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

    // Word store then word load at 0x010.
    do_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0, t);
    do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 1'b0, t);
    wait_idle();
    chk("mem_010", 32'(mem[9'h010]), 32'h0000_00DE);
    chk("mem_011", 32'(mem[9'h011]), 32'h0000_00AD);
    chk("mem_012", 32'(mem[9'h012]), 32'h0000_00BE);
    chk("mem_013", 32'(mem[9'h013]), 32'h0000_00EF);

    // Byte at the top of memory, signed and unsigned loads.
    do_req(1'b1, 2'b00, 1'b0, 9'h1FF, 32'h0000_0080, 1'b0, t);
    do_req(1'b0, 2'b00, 1'b1, 9'h1FF, 32'd0, 1'b0, t);
    do_req(1'b0, 2'b00, 1'b0, 9'h1FF, 32'd0, 1'b0, t);
    wait_idle();
    chk("mem_1ff", 32'(mem[9'h1FF]), 32'h0000_0080);

    // Halfword store/loads and a misaligned halfword.
    do_req(1'b1, 2'b01, 1'b0, 9'h020, 32'h0000_8001, 1'b0, t);
    do_req(1'b0, 2'b01, 1'b1, 9'h020, 32'd0, 1'b0, t);
    do_req(1'b0, 2'b01, 1'b0, 9'h020, 32'd0, 1'b0, t);
    do_req(1'b0, 2'b01, 1'b1, 9'h021, 32'd0, 1'b0, t);
    wait_idle();

    // Misaligned word and illegal size.
    do_req(1'b0, 2'b10, 1'b0, 9'h1FE, 32'd0, 1'b0, t);
    do_req(1'b1, 2'b11, 1'b0, 9'h000, 32'h1234_5678, 1'b0, t);
    wait_idle();

    // Reset during a word store, after two bytes have been written.
    pre42 = ref_mem[9'h042];
    pre43 = ref_mem[9'h043];
    do_req(1'b1, 2'b10, 1'b0, 9'h040, 32'h1122_3344, 1'b0, t);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_ops.delete();
    exp_resp.delete();
    ref_mem[9'h042] = pre42;
    ref_mem[9'h043] = pre43;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 32'(bus.req_ready), 32'd1);
    chk("mem_040", 32'(mem[9'h040]), 32'h0000_0011);
    chk("mem_041", 32'(mem[9'h041]), 32'h0000_0022);
    chk("mem_042", 32'(mem[9'h042]), 32'(pre42));
    chk("mem_043", 32'(mem[9'h043]), 32'(pre43));

    // Back-to-back loads with req_valid held high.
    do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 1'b1, t);
    do_req(1'b0, 2'b00, 1'b1, 9'h1FF, 32'd0, 1'b0, t2);
    chk("b2b_handshake", 32'(t2), 32'(last_resp_cyc + 1));
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
